// File: rtl/jtframe_rom_arbn.sv
// N-slot SDRAM ROM read arbiter with a one-line (32-bit) cache per slot.
// Slots hit from their cached line or queue a line fetch over req/ack/rdy.
module jtframe_rom_arbn #(
    parameter int               SLOTS    = 9,
    parameter int               AW       = 22,
    parameter logic [SLOTS-1:0] DW8_MASK = 9'h0ED,
    parameter int               PRIO_RR  = 0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS*16-1:0]   slot_dout,
    output logic [SLOTS-1:0]      slot_ok,
    output logic                  sdram_req,
    output logic [AW-1:0]         sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [31:0]           data_read
);

    localparam int IW = SLOTS > 1 ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t         st;
    logic [AW-2:0]  line  [SLOTS];
    logic [AW-2:0]  tag   [SLOTS];
    logic [31:0]    cache [SLOTS];
    logic [15:0]    rd    [SLOTS];
    logic [SLOTS-1:0] valid, hit, pending;
    logic [IW-1:0]  gnt, last, pick;
    logic           found;
    logic [AW-2:0]  lat_tag;

    always_comb begin
        logic [AW-1:0] wa;
        logic [15:0]   word;
        logic          bsel;
        for (int n = 0; n < SLOTS; n++) begin
            wa   = slot_addr[n*AW +: AW];
            bsel = 1'b0;
            if (DW8_MASK[n]) begin
                bsel = wa[0];
                wa   = wa >> 1;
            end
            line[n] = wa[AW-1:1];
            word    = wa[0] ? cache[n][31:16] : cache[n][15:0];
            rd[n]   = DW8_MASK[n] ? {8'h00, bsel ? word[15:8] : word[7:0]} : word;
            hit[n]  = slot_cs[n] & valid[n] & (tag[n] == line[n]);
        end
        pending = slot_cs & ~hit;
    end

    // Round-robin searches from last+1 and wraps; fixed priority from slot 0
    always_comb begin
        int k;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            k = i + (PRIO_RR != 0 ? int'(last) + 1 : 0);
            if (k >= SLOTS) k = k - SLOTS;
            if (!found && pending[k]) begin
                found = 1'b1;
                pick  = IW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            valid      <= '0;
            slot_ok    <= '0;
            slot_dout  <= '0;
            last       <= '0;
            gnt        <= '0;
            lat_tag    <= '0;
            for (int n = 0; n < SLOTS; n++) begin
                tag[n]   <= '0;
                cache[n] <= '0;
            end
        end else if (downloading) begin
            st        <= IDLE;
            sdram_req <= 1'b0;
            valid     <= '0;
            slot_ok   <= '0;
        end else begin
            for (int n = 0; n < SLOTS; n++) begin
                slot_ok[n] <= hit[n];
                if (hit[n]) slot_dout[n*16 +: 16] <= rd[n];
            end
            unique case (st)
                IDLE: if (found) begin
                    gnt        <= pick;
                    last       <= pick;
                    lat_tag    <= line[pick];
                    sdram_addr <= {line[pick], 1'b0};
                    sdram_req  <= 1'b1;
                    st         <= WAIT_ACK;
                end
                WAIT_ACK: if (sdram_ack) begin
                    sdram_req <= 1'b0;
                    if (data_rdy) begin
                        cache[gnt] <= data_read;
                        tag[gnt]   <= lat_tag;
                        valid[gnt] <= 1'b1;
                        st         <= IDLE;
                    end else begin
                        st <= WAIT_RDY;
                    end
                end
                WAIT_RDY: if (data_rdy) begin
                    cache[gnt] <= data_read;
                    tag[gnt]   <= lat_tag;
                    valid[gnt] <= 1'b1;
                    st         <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arbn.sv
// Directed bench for jtframe_rom_arbn: fixed-priority instance plus a
// round-robin instance, SDRAM side driven by hand.
module tb_jtframe_rom_arbn;

    localparam int SLOTS = 9;
    localparam int AW    = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic downloading = 1'b0;

    logic [SLOTS-1:0]    cs = '0;
    logic [SLOTS*AW-1:0] addr = '0;
    logic [SLOTS*16-1:0] dout;
    logic [SLOTS-1:0]    ok;
    logic                req;
    logic [AW-1:0]       saddr;
    logic                ack = 1'b0;
    logic                rdy = 1'b0;
    logic [31:0]         rdata = '0;

    logic [SLOTS-1:0]    rcs = '0;
    logic [SLOTS*AW-1:0] raddr = '0;
    logic [SLOTS*16-1:0] rdout;
    logic [SLOTS-1:0]    rok;
    logic                rreq;
    logic [AW-1:0]       rsaddr;
    logic                rack = 1'b0;
    logic                rrdy = 1'b0;
    logic [31:0]         rrdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtframe_rom_arbn u_dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_cs(cs), .slot_addr(addr), .slot_dout(dout), .slot_ok(ok),
        .sdram_req(req), .sdram_addr(saddr), .sdram_ack(ack),
        .data_rdy(rdy), .data_read(rdata)
    );

    jtframe_rom_arbn #(.PRIO_RR(1)) u_rr (
        .clk(clk), .rst(rst), .downloading(1'b0),
        .slot_cs(rcs), .slot_addr(raddr), .slot_dout(rdout), .slot_ok(rok),
        .sdram_req(rreq), .sdram_addr(rsaddr), .sdram_ack(rack),
        .data_rdy(rrdy), .data_read(rrdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int n, input logic [AW-1:0] a);
        addr[n*AW +: AW] = a;
    endtask

    function automatic logic [15:0] dv(input int n);
        return dout[n*16 +: 16];
    endfunction

    task automatic wait_req(input bit r, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((r ? rreq : req) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic serve(input bit r, input bit same, input logic [31:0] d,
                         output bit seen, output logic [AW-1:0] a);
        wait_req(r, seen);
        a = r ? rsaddr : saddr;
        if (!seen) return;
        if (r) rack = 1'b1; else ack = 1'b1;
        if (same) begin
            if (r) begin rrdy = 1'b1; rrdata = d; end
            else   begin rdy  = 1'b1; rdata  = d; end
        end
        tick();
        ack  = 1'b0;
        rack = 1'b0;
        if (!same) begin
            if (r) begin rrdy = 1'b1; rrdata = d; end
            else   begin rdy  = 1'b1; rdata  = d; end
            tick();
        end
        rdy  = 1'b0;
        rrdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cs  = 9'h001;
        repeat (3) tick();
        checks++; if (ok !== '0) begin errors++; $display("FAIL reset_ok got %h want 0", ok); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req); end
        checks++; if (saddr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", saddr); end
        checks++; if (rreq !== 1'b0) begin errors++; $display("FAIL reset_rr_req got %b want 0", rreq); end
        cs  = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fixed_prio();
        bit seen;
        logic [AW-1:0] a;
        set_addr(0, 22'h00005);
        set_addr(3, 22'h00100);
        cs = 9'h009;
        serve(1'b0, 1'b0, 32'hA1B2_C3D4, seen, a);
        checks++; if (!seen || a !== 22'h00002) begin errors++; $display("FAIL prio_first got %h want 000002", a); end
        tick();
        checks++; if (ok[0] !== 1'b1) begin errors++; $display("FAIL prio_ok0 got %b want 1", ok[0]); end
        checks++; if (dv(0) !== 16'h00C3) begin errors++; $display("FAIL prio_dout0 got %h want 00c3", dv(0)); end
        serve(1'b0, 1'b0, 32'h0000_5566, seen, a);
        checks++; if (!seen || a !== 22'h00080) begin errors++; $display("FAIL prio_second got %h want 000080", a); end
        tick();
        checks++; if (ok[3] !== 1'b1) begin errors++; $display("FAIL prio_ok3 got %b want 1", ok[3]); end
        checks++; if (dv(3) !== 16'h0066) begin errors++; $display("FAIL prio_dout3 got %h want 0066", dv(3)); end
    endtask

    task automatic test_8bit();
        bit seen;
        logic [AW-1:0] a;
        set_addr(0, 22'h00006);
        tick();
        checks++; if (ok[0] !== 1'b1) begin errors++; $display("FAIL b8_hit_ok got %b want 1", ok[0]); end
        checks++; if (dv(0) !== 16'h00B2) begin errors++; $display("FAIL b8_hit_dout got %h want 00b2", dv(0)); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL b8_hit_noreq got %b want 0", req); end
        set_addr(0, 22'h00008);
        tick();
        checks++; if (ok[0] !== 1'b0) begin errors++; $display("FAIL b8_miss_ok got %b want 0", ok[0]); end
        checks++; if (dv(0) !== 16'h00B2) begin errors++; $display("FAIL b8_miss_hold got %h want 00b2", dv(0)); end
        serve(1'b0, 1'b0, 32'h0000_00EE, seen, a);
        checks++; if (!seen || a !== 22'h00004) begin errors++; $display("FAIL b8_refetch got %h want 000004", a); end
        tick();
        checks++; if (dv(0) !== 16'h00EE || ok[0] !== 1'b1) begin
            errors++; $display("FAIL b8_fill got %h/%b want 00ee/1", dv(0), ok[0]);
        end
    endtask

    task automatic test_16bit();
        bit seen;
        logic [AW-1:0] a;
        set_addr(1, 22'h00011);
        cs[1] = 1'b1;
        serve(1'b0, 1'b0, 32'h1234_5678, seen, a);
        checks++; if (!seen || a !== 22'h00010) begin errors++; $display("FAIL w16_fetch got %h want 000010", a); end
        checks++; if (ok[1] !== 1'b0) begin errors++; $display("FAIL w16_ok_early got %b want 0", ok[1]); end
        tick();
        checks++; if (ok[1] !== 1'b1 || dv(1) !== 16'h1234) begin
            errors++; $display("FAIL w16_odd got %h/%b want 1234/1", dv(1), ok[1]);
        end
        set_addr(1, 22'h00010);
        tick();
        checks++; if (ok[1] !== 1'b1 || dv(1) !== 16'h5678) begin
            errors++; $display("FAIL w16_even got %h/%b want 5678/1", dv(1), ok[1]);
        end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL w16_noreq got %b want 0", req); end
    endtask

    task automatic test_ack_rdy_same();
        bit seen;
        logic [AW-1:0] a;
        set_addr(4, 22'h00040);
        cs[4] = 1'b1;
        serve(1'b0, 1'b1, 32'hCAFE_BEEF, seen, a);
        checks++; if (!seen || a !== 22'h00040) begin errors++; $display("FAIL same_addr got %h want 000040", a); end
        checks++; if (req !== 1'b0 || ok[4] !== 1'b0) begin
            errors++; $display("FAIL same_after got req %b ok %b want 0 0", req, ok[4]);
        end
        tick();
        checks++; if (ok[4] !== 1'b1 || dv(4) !== 16'hBEEF) begin
            errors++; $display("FAIL same_fill got %h/%b want beef/1", dv(4), ok[4]);
        end
    endtask

    task automatic test_download();
        bit seen;
        logic [AW-1:0] a;
        cs = 9'h012;
        set_addr(1, 22'h00020);
        wait_req(1'b0, seen);
        checks++; if (!seen) begin errors++; $display("FAIL dl_req got 0 want 1"); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        downloading = 1'b1;
        tick();
        checks++; if (req !== 1'b0 || ok !== '0) begin
            errors++; $display("FAIL dl_block got req %b ok %h want 0 000", req, ok);
        end
        rdy   = 1'b1;
        rdata = 32'hDEAD_DEAD;
        tick();
        rdy = 1'b0;
        downloading = 1'b0;
        tick();
        checks++; if (req !== 1'b1 || saddr !== 22'h00020) begin
            errors++; $display("FAIL dl_refetch got %b/%h want 1/000020", req, saddr);
        end
        checks++; if (ok !== '0) begin errors++; $display("FAIL dl_ok got %h want 000", ok); end
        serve(1'b0, 1'b0, 32'h9999_7777, seen, a);
        tick();
        checks++; if (ok[1] !== 1'b1 || dv(1) !== 16'h7777) begin
            errors++; $display("FAIL dl_fill got %h/%b want 7777/1", dv(1), ok[1]);
        end
        serve(1'b0, 1'b0, 32'hCAFE_BEEF, seen, a);
        checks++; if (!seen || a !== 22'h00040) begin errors++; $display("FAIL dl_slot4 got %h want 000040", a); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [AW-1:0] a;
        cs = 9'h002;
        set_addr(1, 22'h00030);
        wait_req(1'b0, seen);
        checks++; if (!seen) begin errors++; $display("FAIL rmid_req got 0 want 1"); end
        rst   = 1'b1;
        cs[1] = 1'b0;
        tick();
        checks++; if (req !== 1'b0 || ok !== '0) begin
            errors++; $display("FAIL rmid_rst got req %b ok %h want 0 000", req, ok);
        end
        rst   = 1'b0;
        rdy   = 1'b1;
        rdata = 32'h5A5A_5A5A;
        tick();
        rdy   = 1'b0;
        cs[1] = 1'b1;
        tick();
        checks++; if (ok[1] !== 1'b0 || req !== 1'b1) begin
            errors++; $display("FAIL rmid_stray got ok %b req %b want 0 1", ok[1], req);
        end
        serve(1'b0, 1'b0, 32'h0000_4321, seen, a);
        checks++; if (!seen || a !== 22'h00030) begin errors++; $display("FAIL rmid_fetch got %h want 000030", a); end
        tick();
        checks++; if (ok[1] !== 1'b1 || dv(1) !== 16'h4321) begin
            errors++; $display("FAIL rmid_fill got %h/%b want 4321/1", dv(1), ok[1]);
        end
    endtask

    task automatic test_round_robin();
        bit seen;
        logic [AW-1:0] a, e;
        int order [3] = '{2, 5, 7};
        int s, r;
        for (int k = 0; k < 3; k++) raddr[order[k]*AW +: AW] = AW'(order[k] * 4096);
        rcs = 9'h0A4;
        for (int i = 0; i < 6; i++) begin
            s = order[i % 3];
            r = i / 3;
            e = AW'((s * 4096 + r * 16) >> 1);
            serve(1'b1, 1'b0, 32'h1111_0000 + i, seen, a);
            checks++; if (!seen || a !== e) begin
                errors++; $display("FAIL rr_grant%0d got %h want %h", i, a, e);
            end
            raddr[s*AW +: AW] = AW'(s * 4096 + (r + 1) * 16);
        end
        rcs = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_prio();
        test_8bit();
        test_16bit();
        test_ack_rdy_same();
        test_download();
        test_reset_mid();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
